// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential unsigned multiply / restoring divide, one bit per clock
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   activate    start strobe, only honoured in IDLE
//   mode        0 = multiply, 1 = divide
//   a, b        multiplicand/dividend, multiplier/divisor
//   result_hi   product upper half / remainder
//   result_lo   product lower half / quotient
//   busy        high while iterating
//   endop       one-cycle completion pulse
//   div_by_zero divide with b == 0, held with the results
module seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             busy,
  output logic             endop,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic op_mode, last, dz, accept;
  logic [WIDTH-1:0] op_a, op_b, acc_hi, acc_lo, nxt_hi, nxt_lo;
  logic [WIDTH:0] add_sum, trial;
  always_comb begin
    accept = state == IDLE && activate;
    last = cnt == CNT_W'(WIDTH - 1);
    state_nxt = state == IDLE ? (activate ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
    dz = op_mode && op_b == '0;
    // multiply: add the multiplicand when the multiplier LSB is set, carry lands in bit WIDTH
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
    // divide: shift the next dividend bit into the remainder and trial-subtract the divisor
    trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b};
    nxt_hi = op_mode ? (trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : trial[WIDTH-1:0])
                     : add_sum[WIDTH:1];
    nxt_lo = op_mode ? {acc_lo[WIDTH-2:0], ~trial[WIDTH]} : {add_sum[0], acc_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      op_mode <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result_hi <= '0;
      result_lo <= '0;
      busy <= 1'b0;
      endop <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      endop <= 1'b0;
      if (accept) begin
        op_mode <= mode;
        op_a <= a;
        op_b <= b;
        acc_hi <= '0;
        acc_lo <= mode ? a : b;
        cnt <= '0;
        busy <= 1'b1;
        div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          busy <= 1'b0;
          endop <= 1'b1;
          result_hi <= dz ? op_a : nxt_hi;
          result_lo <= dz ? '1 : nxt_lo;
          div_by_zero <= dz;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: randomized and directed checks of seq_muldiv at WIDTH 8 and 16
module tb_seq_muldiv;
  logic clk = 1'b0, reset = 1'b0;
  logic act8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, hi8, lo8;
  logic busy8, endop8, dz8;
  logic act16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, hi16, lo16;
  logic busy16, endop16, dz16;
  int pass_cnt = 0, chk_cnt = 0;

  always #5 clk = ~clk;

  seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .activate(act8), .mode(mode8), .a(a8), .b(b8),
    .result_hi(hi8), .result_lo(lo8), .busy(busy8), .endop(endop8), .div_by_zero(dz8)
  );

  seq_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .activate(act16), .mode(mode16), .a(a16), .b(b16),
    .result_hi(hi16), .result_lo(lo16), .busy(busy16), .endop(endop16), .div_by_zero(dz16)
  );

  // reference: {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [16:0] model8(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    logic [7:0] q, r;
    if (!m) begin
      p = x * y;
      return {1'b0, p};
    end
    if (y == 8'd0) return {1'b1, x, 8'hFF};
    q = x / y;
    r = x % y;
    return {1'b0, r, q};
  endfunction

  // start one WIDTH=8 op, scramble inputs during RUN, stop at endop (lat = edges after accept)
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input int pulse_at,
                     output int lat, output bit stable, output logic [16:0] res);
    logic [7:0] ph, pl;
    @(negedge clk);
    ph = hi8;
    pl = lo8;
    mode8 = m;
    a8 = x;
    b8 = y;
    act8 = 1'b1;
    @(negedge clk);
    act8 = 1'b0;
    lat = -1;
    stable = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (endop8) begin
        lat = k;
        break;
      end
      if (!busy8 || hi8 !== ph || lo8 !== pl) stable = 1'b0;
      mode8 = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      act8 = k == pulse_at;
      @(negedge clk);
    end
    act8 = 1'b0;
    res = {dz8, hi8, lo8};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({hi8, lo8, busy8, endop8, dz8} !== '0) $display("FAIL reset8: got %h %h %b%b%b want all 0", hi8, lo8, busy8, endop8, dz8);
    else pass_cnt++;
    chk_cnt++;
    if ({hi16, lo16, busy16, endop16, dz16} !== '0) $display("FAIL reset16: got %h %h %b%b%b want all 0", hi16, lo16, busy16, endop16, dz16);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic m_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] x_t [7] = '{8'd5, 8'd255, 8'd0, 8'd200, 8'd7, 8'd13, 8'd3};
    logic [7:0] y_t [7] = '{8'd2, 8'd255, 8'd200, 8'd7, 8'd200, 8'd0, 8'd3};
    logic [16:0] e_t [7] = '{{1'b0, 8'h00, 8'd10}, {1'b0, 8'hFE, 8'h01}, {1'b0, 8'h00, 8'h00},
                             {1'b0, 8'd4, 8'd28}, {1'b0, 8'd7, 8'd0}, {1'b1, 8'd13, 8'hFF},
                             {1'b0, 8'h00, 8'd9}};
    int lat;
    bit stable;
    logic [16:0] res;
    for (int i = 0; i < 7; i++) begin
      op8(m_t[i], x_t[i], y_t[i], -1, lat, stable, res);
      chk_cnt++;
      if (lat !== 8) $display("FAIL dir_lat[%0d]: got %0d want 8", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (!stable) $display("FAIL dir_run[%0d]: busy low or outputs moved during RUN, want steady", i);
      else pass_cnt++;
      chk_cnt++;
      if (res !== e_t[i]) $display("FAIL dir_res[%0d]: got %h want %h", i, res, e_t[i]);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({endop8, busy8, dz8, hi8, lo8} !== {2'b00, e_t[i]}) $display("FAIL dir_hold[%0d]: got endop=%b busy=%b res=%h want 0 0 %h", i, endop8, busy8, {dz8, hi8, lo8}, e_t[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat;
    bit stable;
    logic [16:0] res, exp;
    logic m;
    logic [7:0] x, y;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp = model8(m, x, y);
      op8(m, x, y, -1, lat, stable, res);
      chk_cnt++;
      if (lat !== 8 || !stable) $display("FAIL rnd_timing[%0d]: lat=%0d stable=%b want 8 1", i, lat, stable);
      else pass_cnt++;
      chk_cnt++;
      if (res !== exp) $display("FAIL rnd_res[%0d] m=%b a=%0d b=%0d: got %h want %h", i, m, x, y, res, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_protocol();
    int lat;
    bit stable, seen;
    logic [16:0] res;
    op8(1'b0, 8'd100, 8'd3, 3, lat, stable, res);
    chk_cnt++;
    if (lat !== 8 || res !== {1'b0, 16'd300}) $display("FAIL run_pulse: lat=%0d res=%h want 8 %h", lat, res, {1'b0, 16'd300});
    else pass_cnt++;
    act8 = 1'b1;
    @(negedge clk);
    act8 = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      if (endop8 || busy8) seen = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen) $display("FAIL done_pulse: got extra busy/endop want none");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    mode8 = 1'b0;
    a8 = 8'd17;
    b8 = 8'd9;
    act8 = 1'b1;
    @(negedge clk);
    act8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({hi8, lo8, busy8, endop8, dz8} !== '0) $display("FAIL mid_reset: got %h %h %b%b%b want all 0", hi8, lo8, busy8, endop8, dz8);
    else pass_cnt++;
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      if (endop8 || busy8) seen = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen) $display("FAIL mid_reset_endop: got busy/endop after abort want none");
    else pass_cnt++;
  endtask

  task automatic test_act_in_reset();
    bit seen;
    reset = 1'b0;
    mode8 = 1'b0;
    a8 = 8'd3;
    b8 = 8'd3;
    act8 = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (busy8 !== 1'b0) $display("FAIL act_reset_busy: got %b want 0", busy8);
    else pass_cnt++;
    act8 = 1'b0;
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      if (endop8 || busy8) seen = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen) $display("FAIL act_reset_start: got busy/endop want stay idle");
    else pass_cnt++;
  endtask

  task automatic test_w16();
    logic m_t [2] = '{1'b0, 1'b1};
    logic [15:0] x_t [2] = '{16'd1000, 16'd65535};
    logic [15:0] y_t [2] = '{16'd300, 16'd256};
    logic [31:0] e_t [2] = '{{16'h0004, 16'h93E0}, {16'd255, 16'd255}};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mode16 = m_t[i];
      a16 = x_t[i];
      b16 = y_t[i];
      act16 = 1'b1;
      @(negedge clk);
      act16 = 1'b0;
      lat = -1;
      for (int k = 0; k <= 60; k++) begin
        if (endop16) begin
          lat = k;
          break;
        end
        @(negedge clk);
      end
      chk_cnt++;
      if (lat !== 16) $display("FAIL w16_lat[%0d]: got %0d want 16", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if ({dz16, hi16, lo16} !== {1'b0, e_t[i]}) $display("FAIL w16_res[%0d]: got %h want %h", i, {dz16, hi16, lo16}, {1'b0, e_t[i]});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_protocol();
    test_reset_mid();
    test_act_in_reset();
    test_w16();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
Parametrised sequential unsigned multiplier/divider, successor to the 8-bit single-function mult unit in alu/arithm. One shared datapath performs either a shift-add multiply or a restoring divide, one bit per clock. It adds a mode select, a full double-width product, a remainder output, a busy flag and divide-by-zero detection. It sits in the ALU arithmetic group and is started by the ALU sequencer with a one-cycle activate strobe.

Parameters:
WIDTH, 8, operand width in bits (WIDTH >= 2)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
activate  input  1  start strobe, sampled only in IDLE
mode  input  1  0 = multiply, 1 = divide
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
result_hi  output  WIDTH  product upper half / remainder
result_lo  output  WIDTH  product lower half / quotient
busy  output  1  high while an operation is in progress (RUN)
endop  output  1  one-cycle completion pulse
div_by_zero  output  1  divide with b==0; valid with endop, held with results

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (reset==0 at a rising clk edge resets).
- Reset: state=IDLE; result_hi, result_lo, busy, endop, div_by_zero, counter and internal registers = 0. Reset overrides every other input, including activate in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE: when activate=1 at an edge, latch a, b and mode, clear the accumulator, set counter=0 and go to RUN. busy=1 from that edge. Outputs keep their previous results.
- RUN: exactly WIDTH iterations, one per edge. activate, mode, a and b are ignored.
  - Multiply: if the current multiplier LSB is 1, add the multiplicand to the upper accumulator (WIDTH+1 bits, carry kept). Then shift {carry,acc_hi,acc_lo} right by 1.
  - Divide: shift {rem,quo} left by 1. Trial-subtract the divisor from rem (WIDTH+1 bits). If the result is non-negative, keep it and set quo LSB=1; otherwise restore rem.
- RUN to DONE: at the WIDTH-th iteration edge, state=DONE. result_hi/result_lo are loaded from the datapath on that edge. busy=0 and endop=1 for exactly that one cycle.
- Multiply result: {result_hi,result_lo} = a*b, exact over 2*WIDTH bits.
- Divide result: result_lo = a/b and result_hi = a%b (unsigned).
- Divide with b==0:
  - Takes the same latency; no early exit.
  - Results are forced to result_lo = all ones and result_hi = a, with div_by_zero=1.
  - div_by_zero is cleared at the next accepted activate.
- DONE: lasts one cycle and returns to IDLE unconditionally. activate during DONE is ignored.
- Latency: with activate accepted at edge T, endop is high in the cycle after edge T+WIDTH. The minimum start-to-start interval is WIDTH+2 cycles.
- Outputs hold their values from DONE until the next DONE or reset. They never change during RUN.
- Reset mid-RUN: aborts immediately. All outputs go to 0, no endop is generated, and the block returns to IDLE.
- Mode and operands are captured only at accept; changes on the inputs during RUN have no effect.

Test Plan:
- WIDTH=8: reset=0 for 2 cycles, then release -> all outputs 0. Then mode=0, a=5, b=2, activate for 1 cycle -> busy high 8 cycles; endop high 1 cycle, 8 edges after accept; result_hi=0, result_lo=10, div_by_zero=0.
- WIDTH=8 multiply 255*255 -> result_hi=0xFE, result_lo=0x01. Then 0*200 -> result_hi=0, result_lo=0.
- WIDTH=8 divide 200/7 -> result_lo=28, result_hi=4. Then divide 7/200 -> result_lo=0, result_hi=7.
- WIDTH=8 divide 13/0 -> same latency; endop=1, div_by_zero=1, result_lo=0xFF, result_hi=13. A following multiply 3*3 clears div_by_zero and gives result_lo=9.
- Protocol checks on WIDTH=8:
  - activate pulsed during RUN and in DONE -> no extra endop.
  - reset=0 at the 4th RUN cycle -> outputs 0, no endop.
  - activate=1 with reset=0 -> stays IDLE.
- WIDTH=16: multiply 1000*300 -> {hi,lo}=300000 (hi=0x0004, lo=0x93E0). Divide 65535/256 -> q=255, r=255. endop 16 edges after accept.
